// File: rtl/timer_pkg.sv
// Shared definitions for the programmable interval timer.
//   state_t        : controller state (IDLE, RUN)
//   MODE_*         : encodings of the mode input
//   calc_div       : clock cycles per tick, CLK_HZ / TICK_HZ
//   calc_pre_w     : prescaler width needed to count 0..DIV-1
package timer_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_t;

  localparam logic MODE_ONESHOT  = 1'b0;
  localparam logic MODE_PERIODIC = 1'b1;

  // A zero tick rate yields DIV 0, which the top rejects at elaboration.
  function automatic int unsigned calc_div(input int unsigned clk_hz,
                                           input int unsigned tick_hz);
    return (tick_hz == 0) ? 0 : clk_hz / tick_hz;
  endfunction

  // Never narrower than one bit, so degenerate DIV values still elaborate
  // far enough to reach the DIV range check.
  function automatic int unsigned calc_pre_w(input int unsigned div);
    return (div < 2) ? 1 : $clog2(div);
  endfunction

endpackage

// File: rtl/tick_prescaler.sv
// Clock prescaler: divides clk down to one wrap pulse every DIV enabled cycles.
//   clk  : system clock, rising edge
//   rst  : synchronous, active-low reset
//   run  : advance the prescaler this cycle (state RUN and enable high)
//   clr  : force the prescaler back to 0 (start or stop); wins over run
//   wrap : combinational, high while run is high and the prescaler sits at DIV-1
module tick_prescaler #(
  parameter int unsigned DIV = 10
) (
  input  logic clk,
  input  logic rst,
  input  logic run,
  input  logic clr,
  output logic wrap
);
  import timer_pkg::*;

  localparam int unsigned   PRE_W = calc_pre_w(DIV);
  localparam logic [PRE_W-1:0] LAST  = PRE_W'(DIV - 1);
  localparam logic [PRE_W-1:0] ONE   = PRE_W'(1);

  logic [PRE_W-1:0] pre;

  assign wrap = run && (pre == LAST);

  // Holds while run is low; wrapping back to 0 also covers leaving RUN on a
  // one-shot expiry, so the parent only needs to clear on start and stop.
  always_ff @(posedge clk) begin
    if (!rst) begin
      pre <= '0;
    end else if (clr) begin
      pre <= '0;
    end else if (run) begin
      if (pre == LAST) begin
        pre <= '0;
      end else begin
        pre <= pre + ONE;
      end
    end
  end

endmodule

// File: rtl/prog_interval_timer.sv
// Programmable interval timer with one-shot and periodic modes, pause and abort.
//   clk      : system clock, rising edge
//   rst      : synchronous, active-low reset
//   enable   : 1 advances prescaler and counter, 0 pauses
//   start    : one-cycle pulse, loads load_val and begins counting
//   stop     : one-cycle pulse, aborts the run (count holds)
//   mode     : 0 one-shot, 1 periodic; sampled on start only
//   load_val : ticks to expiry; sampled on start only
//   count    : remaining ticks
//   tick     : one-cycle pulse per elapsed tick
//   expired  : one-cycle pulse when count reaches 0
//   busy     : high while state is RUN
module prog_interval_timer #(
  parameter int unsigned CLK_HZ  = 50000000,
  parameter int unsigned TICK_HZ = 1,
  parameter int unsigned CNT_W   = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             enable,
  input  logic             start,
  input  logic             stop,
  input  logic             mode,
  input  logic [CNT_W-1:0] load_val,
  output logic [CNT_W-1:0] count,
  output logic             tick,
  output logic             expired,
  output logic             busy
);
  import timer_pkg::*;

  localparam int unsigned      DIV     = calc_div(CLK_HZ, TICK_HZ);
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  generate
    if (DIV < 2) begin : g_div_check
      $error("prog_interval_timer: CLK_HZ/TICK_HZ must be at least 2");
    end
  endgenerate

  state_t           state;
  logic [CNT_W-1:0] reload;
  logic             mode_q;
  logic             pre_run;
  logic             pre_clr;
  logic             wrap;

  assign pre_run = (state == RUN) && enable;
  assign pre_clr = start || stop;

  tick_prescaler #(
    .DIV (DIV)
  ) u_prescaler (
    .clk  (clk),
    .rst  (rst),
    .run  (pre_run),
    .clr  (pre_clr),
    .wrap (wrap)
  );

  // Controller: priority is reset, then start, then stop, then tick processing.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state   <= IDLE;
      count   <= '0;
      reload  <= '0;
      mode_q  <= MODE_ONESHOT;
      tick    <= 1'b0;
      expired <= 1'b0;
      busy    <= 1'b0;
    end else begin
      tick    <= 1'b0;
      expired <= 1'b0;

      if (start) begin
        // A due tick is swallowed by the restart.
        if (load_val != '0) begin
          count  <= load_val;
          reload <= load_val;
          mode_q <= mode;
          state  <= RUN;
          busy   <= 1'b1;
        end else begin
          // Zero-length interval expires immediately in either mode.
          count   <= '0;
          expired <= 1'b1;
          state   <= IDLE;
          busy    <= 1'b0;
        end
      end else if (stop) begin
        if (state == RUN) begin
          state <= IDLE;
          busy  <= 1'b0;
        end
      end else if (wrap) begin
        tick <= 1'b1;
        if (count == CNT_ONE) begin
          expired <= 1'b1;
          if (mode_q == MODE_PERIODIC) begin
            count <= reload;
          end else begin
            count <= '0;
            state <= IDLE;
            busy  <= 1'b0;
          end
        end else begin
          count <= count - CNT_ONE;
        end
      end
    end
  end

endmodule

// File: tb/tb_prog_interval_timer.sv
// Self-checking bench for prog_interval_timer at CLK_HZ=10, TICK_HZ=1 (DIV=10).
module tb_prog_interval_timer;

  localparam int unsigned CLK_HZ  = 10;
  localparam int unsigned TICK_HZ = 1;
  localparam int unsigned CNT_W   = 8;
  localparam int          DIV     = 10;

  logic             clk = 1'b0;
  logic             rst = 1'b0;
  logic             enable = 1'b0;
  logic             start = 1'b0;
  logic             stop = 1'b0;
  logic             mode = 1'b0;
  logic [CNT_W-1:0] load_val = '0;
  logic [CNT_W-1:0] count;
  logic             tick;
  logic             expired;
  logic             busy;

  int n_vec = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  prog_interval_timer #(
    .CLK_HZ  (CLK_HZ),
    .TICK_HZ (TICK_HZ),
    .CNT_W   (CNT_W)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .enable   (enable),
    .start    (start),
    .stop     (stop),
    .mode     (mode),
    .load_val (load_val),
    .count    (count),
    .tick     (tick),
    .expired  (expired),
    .busy     (busy)
  );

  // Reference model: counts enabled run cycles since the last start; a tick
  // falls on every multiple of DIV.
  bit m_run, m_mode, m_tick, m_exp;
  int m_el, m_cnt, m_rel;

  always @(posedge clk) begin
    bit n_run, n_mode, n_tick, n_exp;
    int n_el, n_cnt, n_rel;
    n_run = m_run; n_mode = m_mode; n_el = m_el; n_cnt = m_cnt; n_rel = m_rel;
    n_tick = 1'b0; n_exp = 1'b0;
    if (!rst) begin
      n_run = 0; n_mode = 0; n_el = 0; n_cnt = 0; n_rel = 0;
    end else if (start) begin
      n_el = 0;
      if (load_val == 0) begin
        n_cnt = 0; n_exp = 1; n_run = 0;
      end else begin
        n_cnt = int'(load_val); n_rel = n_cnt; n_mode = mode; n_run = 1;
      end
    end else if (stop) begin
      n_run = 0; n_el = 0;
    end else if (m_run && enable) begin
      n_el = m_el + 1;
      if (n_el % DIV == 0) begin
        n_tick = 1;
        if (m_cnt == 1) begin
          n_exp = 1;
          if (m_mode) n_cnt = m_rel;
          else begin n_cnt = 0; n_run = 0; end
        end else begin
          n_cnt = m_cnt - 1;
        end
      end
    end
    m_run <= n_run; m_mode <= n_mode; m_el <= n_el; m_cnt <= n_cnt;
    m_rel <= n_rel; m_tick <= n_tick; m_exp <= n_exp;
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b0; start = 1'b1; load_val = 8'd5; enable = 1'b1;
    for (int k = 0; k < 3; k++) begin
      step();
      n_vec++;
      if (count !== 8'd0 || tick !== 1'b0 || expired !== 1'b0 || busy !== 1'b0) begin
        n_err++;
        $display("FAIL reset k=%0d: count=%0d tick=%b expired=%b busy=%b, want 0 0 0 0",
                 k, count, tick, expired, busy);
      end
    end
    rst = 1'b1; start = 1'b0; load_val = '0;
    for (int k = 0; k < 15; k++) begin
      step();
      n_vec++;
      if (count !== 8'd0 || tick !== 1'b0 || busy !== 1'b0) begin
        n_err++;
        $display("FAIL reset_release k=%0d: count=%0d tick=%b busy=%b, want 0 0 0",
                 k, count, tick, busy);
      end
    end
  endtask

  task automatic test_oneshot();
    logic [7:0] e_cnt;
    logic e_tick, e_exp, e_busy;
    mode = 1'b0; load_val = 8'd3; enable = 1'b1; start = 1'b1;
    step();
    start = 1'b0; load_val = 8'd0; mode = 1'b1;  // ignored mid-run
    n_vec++;
    if (count !== 8'd3 || busy !== 1'b1 || tick !== 1'b0) begin
      n_err++;
      $display("FAIL oneshot_load: count=%0d busy=%b tick=%b, want 3 1 0", count, busy, tick);
    end
    for (int k = 1; k <= 35; k++) begin
      step();
      e_tick = (k % 10 == 0) && (k <= 30);
      e_exp  = (k == 30);
      e_busy = (k < 30);
      e_cnt  = (k >= 30) ? 8'd0 : 8'(3 - k / 10);
      n_vec++;
      if (count !== e_cnt || tick !== e_tick || expired !== e_exp || busy !== e_busy) begin
        n_err++;
        $display("FAIL oneshot k=%0d: count=%0d tick=%b expired=%b busy=%b, want %0d %b %b %b",
                 k, count, tick, expired, busy, e_cnt, e_tick, e_exp, e_busy);
      end
    end
    mode = 1'b0;
  endtask

  task automatic test_periodic();
    logic [7:0] e_cnt;
    mode = 1'b1; load_val = 8'd2; enable = 1'b1; start = 1'b1;
    step();
    start = 1'b0; mode = 1'b0; load_val = 8'd9;  // ignored mid-run
    for (int k = 1; k <= 64; k++) begin
      step();
      e_cnt = (((k / 10) % 2) == 1) ? 8'd1 : 8'd2;
      n_vec++;
      if (count !== e_cnt || tick !== (k % 10 == 0) || expired !== (k % 20 == 0) ||
          busy !== 1'b1) begin
        n_err++;
        $display("FAIL periodic k=%0d: count=%0d tick=%b expired=%b busy=%b, want %0d %b %b 1",
                 k, count, tick, expired, busy, e_cnt, (k % 10 == 0), (k % 20 == 0));
      end
    end
    stop = 1'b1;
    step();
    stop = 1'b0;
    for (int k = 65; k <= 80; k++) begin
      n_vec++;
      if (busy !== 1'b0 || count !== 8'd2 || expired !== 1'b0 || tick !== 1'b0) begin
        n_err++;
        $display("FAIL periodic_stop k=%0d: count=%0d tick=%b expired=%b busy=%b, want 2 0 0 0",
                 k, count, tick, expired, busy);
      end
      step();
    end
  endtask

  task automatic test_pause();
    mode = 1'b0; load_val = 8'd1; enable = 1'b1; start = 1'b1;
    step();
    start = 1'b0;
    for (int k = 1; k <= 22; k++) begin
      enable = !(k >= 5 && k <= 9);
      step();
      n_vec++;
      if (tick !== (k == 15) || expired !== (k == 15) || busy !== (k < 15)) begin
        n_err++;
        $display("FAIL pause k=%0d: tick=%b expired=%b busy=%b, want %b %b %b",
                 k, tick, expired, busy, (k == 15), (k == 15), (k < 15));
      end
    end
    enable = 1'b1;
  endtask

  task automatic test_collisions();
    // Restart on the edge where a tick is due.
    mode = 1'b0; load_val = 8'd3; enable = 1'b1; start = 1'b1;
    step();
    start = 1'b0;
    repeat (9) step();
    start = 1'b1; load_val = 8'd5;
    step();
    start = 1'b0;
    n_vec++;
    if (tick !== 1'b0 || expired !== 1'b0 || count !== 8'd5 || busy !== 1'b1) begin
      n_err++;
      $display("FAIL restart_on_tick: tick=%b expired=%b count=%0d busy=%b, want 0 0 5 1",
               tick, expired, count, busy);
    end
    for (int k = 1; k <= 10; k++) begin
      step();
      n_vec++;
      if (tick !== (k == 10) || count !== ((k == 10) ? 8'd4 : 8'd5)) begin
        n_err++;
        $display("FAIL restart_next_tick k=%0d: tick=%b count=%0d, want %b %0d",
                 k, tick, count, (k == 10), (k == 10) ? 4 : 5);
      end
    end
    // Start and stop together: start wins.
    start = 1'b1; stop = 1'b1; load_val = 8'd7;
    step();
    start = 1'b0; stop = 1'b0;
    n_vec++;
    if (busy !== 1'b1 || count !== 8'd7) begin
      n_err++;
      $display("FAIL start_stop: busy=%b count=%0d, want 1 7", busy, count);
    end
    repeat (3) step();
    // Zero load expires on the next edge.
    start = 1'b1; load_val = 8'd0; mode = 1'b1;
    step();
    start = 1'b0; mode = 1'b0;
    n_vec++;
    if (expired !== 1'b1 || busy !== 1'b0 || count !== 8'd0 || tick !== 1'b0) begin
      n_err++;
      $display("FAIL zero_load: expired=%b busy=%b count=%0d tick=%b, want 1 0 0 0",
               expired, busy, count, tick);
    end
    for (int k = 1; k <= 15; k++) begin
      step();
      n_vec++;
      if (expired !== 1'b0 || tick !== 1'b0 || busy !== 1'b0) begin
        n_err++;
        $display("FAIL zero_load_after k=%0d: expired=%b tick=%b busy=%b, want 0 0 0",
                 k, expired, tick, busy);
      end
    end
  endtask

  task automatic test_reset_midrun();
    mode = 1'b0; load_val = 8'd4; enable = 1'b1; start = 1'b1;
    step();
    start = 1'b0;
    repeat (12) step();
    rst = 1'b0;
    step();
    rst = 1'b1;
    n_vec++;
    if (count !== 8'd0 || tick !== 1'b0 || expired !== 1'b0 || busy !== 1'b0) begin
      n_err++;
      $display("FAIL reset_midrun: count=%0d tick=%b expired=%b busy=%b, want 0 0 0 0",
               count, tick, expired, busy);
    end
    for (int k = 1; k <= 30; k++) begin
      step();
      n_vec++;
      if (tick !== 1'b0 || busy !== 1'b0 || expired !== 1'b0) begin
        n_err++;
        $display("FAIL reset_midrun_after k=%0d: tick=%b busy=%b expired=%b, want 0 0 0",
                 k, tick, busy, expired);
      end
    end
  endtask

  task automatic test_random();
    for (int k = 0; k < 4000; k++) begin
      rst      = ($urandom_range(0, 299) != 0);
      start    = ($urandom_range(0, 39) == 0);
      stop     = ($urandom_range(0, 59) == 0);
      enable   = ($urandom_range(0, 4) != 0);
      mode     = 1'($urandom_range(0, 1));
      load_val = 8'($urandom_range(0, 4));
      step();
      n_vec++;
      if (count !== 8'(m_cnt) || tick !== m_tick || expired !== m_exp || busy !== m_run) begin
        n_err++;
        $display("FAIL random k=%0d: count=%0d tick=%b expired=%b busy=%b, want %0d %b %b %b",
                 k, count, tick, expired, busy, m_cnt, m_tick, m_exp, m_run);
      end
    end
    rst = 1'b1; start = 1'b0; stop = 1'b0; enable = 1'b1;
  endtask

  initial begin
    test_reset();
    test_oneshot();
    test_periodic();
    test_pause();
    test_collisions();
    test_reset_midrun();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
